// File: rtl/mips_ni_ctrl.sv
// mips_ni_ctrl: network interface linking the MIPS core send/receive path to its local NoC router port
module mips_ni_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 2,
   parameter int NODE_ID  = 0,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       proc_valid,
   input  logic [ADDR_W-1:0]          proc_dest,
   input  logic [DATA_W-1:0]          proc_data,
   input  logic                       proc_ready_in,
   output logic                       proc_stall,
   output logic                       data_valid,
   output logic [DATA_W-1:0]          wd_NI,
   output logic [ADDR_W-1:0]          rx_src,
   output logic                       mips_ni,
   output logic [2*ADDR_W+DATA_W-1:0] flit_out,
   output logic                       flit_out_valid,
   input  logic                       flit_out_ready,
   input  logic [2*ADDR_W+DATA_W-1:0] flit_in,
   input  logic                       flit_in_valid,
   output logic                       flit_in_ready,
   output logic [7:0]                 misroute_cnt
);
   localparam int FW  = 2*ADDR_W+DATA_W;
   localparam int TPW = $clog2(TX_DEPTH);
   localparam int RPW = $clog2(RX_DEPTH);
   localparam logic [ADDR_W-1:0] ME = ADDR_W'(NODE_ID);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DELIVER} state_t;
   state_t state, state_nx;
   logic [FW-1:0] tx_mem [TX_DEPTH];
   logic [FW-1:0] rx_mem [RX_DEPTH];
   logic [TPW-1:0] tx_wr, tx_rd;
   logic [RPW-1:0] rx_wr, rx_rd;
   logic [TPW:0] tx_cnt;
   logic [RPW:0] rx_cnt;
   logic tx_full, tx_empty, tx_push, tx_pop;
   logic rx_full, rx_empty, rx_accept, rx_push, rx_pop, misrouted;
   assign tx_full        = tx_cnt[TPW];
   assign tx_empty       = tx_cnt == '0;
   assign tx_push        = proc_valid && !tx_full;
   assign tx_pop         = flit_out_valid && flit_out_ready;
   assign flit_out_valid = !tx_empty;
   assign flit_out       = tx_empty ? '0 : tx_mem[tx_rd];
   assign rx_full        = rx_cnt[RPW];
   assign rx_empty       = rx_cnt == '0;
   assign flit_in_ready  = !rx_full;
   assign rx_accept      = flit_in_valid && flit_in_ready;
   assign rx_push        = rx_accept && flit_in[FW-1 -: ADDR_W] == ME;
   assign misrouted      = rx_accept && flit_in[FW-1 -: ADDR_W] != ME;
   assign rx_pop         = state == S_DELIVER;
   assign mips_ni        = !rx_empty;
   // masked during reset so the core is never frozen while the interface is held in reset
   assign proc_stall     = rst && ((proc_ready_in && state != S_DELIVER) || (proc_valid && tx_full));
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= {proc_dest, ME, proc_data};
      if (rx_push) rx_mem[rx_wr] <= flit_in;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wr        <= '0;
         tx_rd        <= '0;
         tx_cnt       <= '0;
         rx_wr        <= '0;
         rx_rd        <= '0;
         rx_cnt       <= '0;
         misroute_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop) tx_rd <= tx_rd + 1'b1;
         tx_cnt <= tx_cnt + {{TPW{1'b0}}, tx_push} - {{TPW{1'b0}}, tx_pop};
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop) rx_rd <= rx_rd + 1'b1;
         rx_cnt <= rx_cnt + {{RPW{1'b0}}, rx_push} - {{RPW{1'b0}}, rx_pop};
         if (misrouted && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
      end
   end
   always_comb begin
      state_nx = state;
      if (state == S_DELIVER) state_nx = S_IDLE;
      else if (state == S_WAIT || proc_ready_in) state_nx = rx_empty ? S_WAIT : S_DELIVER;
   end
   // delivery outputs are loaded on entry to DELIVER so they are valid throughout that state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         data_valid <= 1'b0;
         wd_NI      <= '0;
         rx_src     <= '0;
      end else begin
         state      <= state_nx;
         data_valid <= state_nx == S_DELIVER;
         if (state_nx == S_DELIVER) begin
            wd_NI  <= rx_mem[rx_rd][DATA_W-1:0];
            rx_src <= rx_mem[rx_rd][DATA_W +: ADDR_W];
         end
      end
   end
endmodule

// File: tb/tb_mips_ni_ctrl.sv
// tb_mips_ni_ctrl: directed and randomized checks of mips_ni_ctrl against a queue-based transaction model
module tb_mips_ni_ctrl;
   localparam logic [1:0] ME = 2'd1;
   logic clk = 1'b0, rst = 1'b1;
   logic proc_valid = 0, proc_ready_in = 0, flit_out_ready = 0, flit_in_valid = 0;
   logic [1:0] proc_dest = 0;
   logic [31:0] proc_data = 0;
   logic [35:0] flit_in = 0;
   logic proc_stall, data_valid, mips_ni, flit_out_valid, flit_in_ready;
   logic [31:0] wd_NI;
   logic [1:0] rx_src;
   logic [35:0] flit_out;
   logic [7:0] misroute_cnt;
   logic [82:0] obs, exp_v;
   int checks = 0, errors = 0;
   logic [35:0] tx_q[$], rx_q[$];
   int mis;
   bit waiting, dv;
   logic [31:0] m_wd;
   logic [1:0] m_src;

   mips_ni_ctrl #(.DATA_W(32), .ADDR_W(2), .NODE_ID(1), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .proc_valid(proc_valid), .proc_dest(proc_dest), .proc_data(proc_data),
      .proc_ready_in(proc_ready_in), .proc_stall(proc_stall), .data_valid(data_valid), .wd_NI(wd_NI),
      .rx_src(rx_src), .mips_ni(mips_ni), .flit_out(flit_out), .flit_out_valid(flit_out_valid),
      .flit_out_ready(flit_out_ready), .flit_in(flit_in), .flit_in_valid(flit_in_valid),
      .flit_in_ready(flit_in_ready), .misroute_cnt(misroute_cnt));

   always #5 clk = ~clk;
   assign obs = {proc_stall, data_valid, wd_NI, rx_src, mips_ni, flit_out, flit_out_valid, flit_in_ready, misroute_cnt};

   initial begin
      #1000000;
      $display("FAIL timeout");
      $fatal(1);
   end

   // a receive in progress completes the cycle after the RX queue holds a word
   function automatic logic [82:0] model_out();
      logic [35:0] head;
      head = tx_q.size() > 0 ? tx_q[0] : 36'h0;
      return {rst && ((proc_ready_in && !dv) || (proc_valid && tx_q.size() == 4)), dv, m_wd, m_src,
              rx_q.size() > 0, head, tx_q.size() > 0, rx_q.size() < 4, 8'(mis)};
   endfunction

   task automatic model_clear();
      tx_q.delete();
      rx_q.delete();
      mis = 0;
      dv = 0;
      waiting = 0;
      m_wd = 0;
      m_src = 0;
   endtask

   task automatic model_step();
      bit acc, tpush, nd, nw;
      acc = flit_in_valid && rx_q.size() < 4;
      tpush = proc_valid && tx_q.size() < 4;
      nd = 0;
      nw = 0;
      if (!dv && (waiting || proc_ready_in)) begin
         if (rx_q.size() > 0) begin
            nd = 1;
            m_wd = rx_q[0][31:0];
            m_src = rx_q[0][33:32];
         end else nw = 1;
      end
      if (dv) void'(rx_q.pop_front());
      if (acc) begin
         if (flit_in[35:34] == ME) rx_q.push_back(flit_in);
         else if (mis < 255) mis++;
      end
      if (tx_q.size() > 0 && flit_out_ready) void'(tx_q.pop_front());
      if (tpush) tx_q.push_back({proc_dest, ME, proc_data});
      dv = nd;
      waiting = nw;
   endtask

   task automatic idle_inputs();
      proc_valid = 0;
      proc_ready_in = 0;
      flit_in_valid = 0;
      flit_out_ready = 0;
      proc_dest = 0;
      proc_data = 0;
      flit_in = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      #1 rst = 0;
      model_clear();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 rst = 0;
      model_clear();
      #1;
      checks++;
      exp_v = model_out();
      if (obs !== exp_v) begin errors++; $display("FAIL reset obs=%h exp=%h", obs, exp_v); end
      checks++;
      if (flit_in_ready !== 1'b1 || flit_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready flit_in_ready=%b flit_out_valid=%b exp 1 0", flit_in_ready, flit_out_valid);
      end
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_send();
      flit_out_ready = 1;
      proc_valid = 1;
      proc_dest = 2'd2;
      proc_data = 32'hDEADBEEF;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL send c=%0d obs=%h exp=%h", c, obs, exp_v); end
         if (c == 1) begin
            checks++;
            if (flit_out !== 36'h9DEADBEEF || flit_out_valid !== 1'b1 || proc_stall !== 1'b0) begin
               errors++;
               $display("FAIL send_flit flit=%h v=%b stall=%b exp 9deadbeef 1 0", flit_out, flit_out_valid, proc_stall);
            end
         end
         model_step();
         @(negedge clk);
         proc_valid = 0;
      end
      idle_inputs();
   endtask

   task automatic test_tx_full();
      logic [31:0] got[$];
      int stall_cyc;
      bit pushed;
      stall_cyc = 0;
      flit_out_ready = 0;
      for (int k = 1; k <= 5; k++) begin
         proc_valid = 1;
         proc_dest = 2'd2;
         proc_data = 32'(k);
         pushed = 0;
         for (int c = 0; c < 20 && !pushed; c++) begin
            if (tx_q.size() == 4) stall_cyc++;
            if (stall_cyc > 3) flit_out_ready = 1;
            #1;
            checks++;
            exp_v = model_out();
            if (obs !== exp_v) begin errors++; $display("FAIL tx_full k=%0d obs=%h exp=%h", k, obs, exp_v); end
            if (tx_q.size() == 4) begin
               checks++;
               if (proc_stall !== 1'b1) begin errors++; $display("FAIL tx_full_stall stall=%b exp 1", proc_stall); end
            end
            if (flit_out_valid && flit_out_ready) got.push_back(flit_out[31:0]);
            pushed = tx_q.size() < 4;
            model_step();
            @(negedge clk);
         end
      end
      proc_valid = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL tx_drain obs=%h exp=%h", obs, exp_v); end
         if (flit_out_valid && flit_out_ready) got.push_back(flit_out[31:0]);
         model_step();
         @(negedge clk);
      end
      checks++;
      if (got.size() != 5) begin errors++; $display("FAIL tx_order_count got=%0d exp=5", got.size()); end
      for (int i = 0; i < got.size() && i < 5; i++) begin
         checks++;
         if (got[i] !== 32'(i + 1)) begin errors++; $display("FAIL tx_order i=%0d got=%h exp=%h", i, got[i], i + 1); end
      end
      idle_inputs();
   endtask

   task automatic test_receive();
      flit_in = 36'h712345678;
      for (int c = 0; c < 6; c++) begin
         flit_in_valid = c == 0;
         proc_ready_in = c == 3;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL receive c=%0d obs=%h exp=%h", c, obs, exp_v); end
         if (c == 3) begin
            checks++;
            if (proc_stall !== 1'b1) begin errors++; $display("FAIL receive_stall stall=%b exp 1", proc_stall); end
         end
         if (c == 4) begin
            checks++;
            if (data_valid !== 1'b1 || wd_NI !== 32'h12345678 || rx_src !== 2'd3 || proc_stall !== 1'b0) begin
               errors++;
               $display("FAIL receive_data dv=%b wd=%h src=%0d stall=%b exp 1 12345678 3 0", data_valid, wd_NI, rx_src, proc_stall);
            end
         end
         if (c == 5) begin
            checks++;
            if (mips_ni !== 1'b0 || data_valid !== 1'b0) begin
               errors++;
               $display("FAIL receive_after mips_ni=%b dv=%b exp 0 0", mips_ni, data_valid);
            end
         end
         model_step();
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_receive_empty();
      int acc_cyc, dv_cnt, dv_cyc;
      acc_cyc = -1;
      dv_cnt = 0;
      dv_cyc = -1;
      flit_in = {ME, 2'd2, 32'h0000CAFE};
      for (int c = 0; c < 20; c++) begin
         flit_in_valid = c == 10;
         proc_ready_in = c < 12;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL rx_empty c=%0d obs=%h exp=%h", c, obs, exp_v); end
         if (flit_in_valid && flit_in_ready) acc_cyc = c;
         if (data_valid) begin dv_cnt++; dv_cyc = c; end
         model_step();
         @(negedge clk);
      end
      checks++;
      if (dv_cnt != 1 || dv_cyc != acc_cyc + 2 || wd_NI !== 32'h0000CAFE) begin
         errors++;
         $display("FAIL rx_empty_pulse count=%0d at=%0d wd=%h exp 1 %0d 0000cafe", dv_cnt, dv_cyc, wd_NI, acc_cyc + 2);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      int dv_cnt;
      dv_cnt = 0;
      for (int c = 0; c < 9; c++) begin
         flit_in_valid = c < 3;
         flit_in = {ME, 2'(c), 32'hA000_0000 + 32'(c)};
         proc_ready_in = c >= 3 && c % 2 == 1;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL b2b c=%0d obs=%h exp=%h", c, obs, exp_v); end
         if (data_valid) dv_cnt++;
         model_step();
         @(negedge clk);
      end
      checks++;
      if (dv_cnt != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", dv_cnt); end
      idle_inputs();
   endtask

   task automatic test_misroute_full();
      for (int c = 0; c < 16; c++) begin
         flit_in_valid = c < 5 || (c >= 7 && c < 10);
         flit_in = c == 0 ? {2'd2, 2'd0, 32'hBAD0_0000} : {ME, 2'd3, 32'h5000_0000 + 32'(c)};
         proc_ready_in = c == 6;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL misroute c=%0d obs=%h exp=%h", c, obs, exp_v); end
         if (c == 1) begin
            checks++;
            if (misroute_cnt !== 8'd1 || mips_ni !== 1'b0) begin
               errors++;
               $display("FAIL misroute_one cnt=%0d mips_ni=%b exp 1 0", misroute_cnt, mips_ni);
            end
         end
         if (c == 6 || c == 10) begin
            checks++;
            if (flit_in_ready !== 1'b0) begin errors++; $display("FAIL rx_full c=%0d ready=%b exp 0", c, flit_in_ready); end
         end
         model_step();
         @(negedge clk);
      end
      for (int c = 0; c < 8; c++) begin
         flit_in_valid = 0;
         proc_ready_in = c % 2 == 0;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL rx_drain c=%0d obs=%h exp=%h", c, obs, exp_v); end
         model_step();
         @(negedge clk);
      end
      proc_ready_in = 0;
      flit_in_valid = 1;
      flit_in = {2'd3, 2'd0, 32'h0};
      for (int c = 0; c < 260; c++) begin
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL misroute_sat c=%0d obs=%h exp=%h", c, obs, exp_v); end
         model_step();
         @(negedge clk);
      end
      #1;
      checks++;
      if (misroute_cnt !== 8'd255) begin errors++; $display("FAIL misroute_sat_final cnt=%0d exp 255", misroute_cnt); end
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         proc_valid = $urandom_range(0, 2) == 0;
         proc_dest = 2'($urandom_range(0, 3));
         proc_data = $urandom;
         flit_out_ready = $urandom_range(0, 3) != 0;
         flit_in_valid = $urandom_range(0, 1) == 1;
         flit_in = {$urandom_range(0, 5) == 0 ? 2'($urandom_range(0, 3)) : ME, 2'($urandom_range(0, 3)), 32'($urandom)};
         proc_ready_in = $urandom_range(0, 3) == 0;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL random c=%0d obs=%h exp=%h", c, obs, exp_v); end
         model_step();
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         proc_valid = c < 3;
         proc_data = 32'h100 + 32'(c);
         proc_dest = 2'd3;
         proc_ready_in = c >= 3;
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_setup c=%0d obs=%h exp=%h", c, obs, exp_v); end
         model_step();
         @(negedge clk);
      end
      proc_valid = 0;
      rst = 0;
      model_clear();
      #1;
      checks++;
      if (flit_out_valid !== 1'b0 || proc_stall !== 1'b0 || mips_ni !== 1'b0 || flit_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid v=%b stall=%b mips_ni=%b ready=%b exp 0 0 0 1", flit_out_valid, proc_stall, mips_ni, flit_in_ready);
      end
      @(negedge clk);
      rst = 1;
      proc_ready_in = 0;
      for (int c = 0; c < 5; c++) begin
         flit_in_valid = c == 0;
         flit_in = {ME, 2'd2, 32'h77};
         #1;
         checks++;
         exp_v = model_out();
         if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_after c=%0d obs=%h exp=%h", c, obs, exp_v); end
         model_step();
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_send();
      test_tx_full();
      test_receive();
      test_receive_empty();
      test_back_to_back();
      test_misroute_full();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_ni_ctrl.md
Name: mips_ni_ctrl

Overview:
- Network-interface controller between the 5-stage MIPS core and its local NoC router port.
- Send path: buffers processor send requests (execute-stage data, destination, valid) in a TX FIFO and emits 36-bit flits to the router under valid/ready.
- Receive path: buffers router flits in an RX FIFO and sequences delivery to the core's receive instruction through an FSM.
- Stalls the pipeline when a send finds TX full, or a receive finds no data.

Parameters:
- DATA_W, 32, payload width (core word).
- ADDR_W, 2, node address width (4-node mesh).
- NODE_ID, 0, this node's address; stamped as the flit source; checked against incoming dest.
- TX_DEPTH, 4, TX FIFO entries (power of 2).
- RX_DEPTH, 4, RX FIFO entries (power of 2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- proc_valid  in  1  core send request (execute stage).
- proc_dest  in  ADDR_W  send destination.
- proc_data  in  DATA_W  send payload.
- proc_ready_in  in  1  core receive request; held while stalled.
- proc_stall  out  1  freeze core pipeline.
- data_valid  out  1  receive data valid to core (one-cycle pulse).
- wd_NI  out  DATA_W  received payload to core register write.
- rx_src  out  ADDR_W  source node of the delivered word.
- mips_ni  out  1  RX FIFO non-empty (message pending).
- flit_out  out  2*ADDR_W+DATA_W  {dest, src, payload}, dest in MSBs.
- flit_out_valid  out  1  TX head valid.
- flit_out_ready  in  1  router accepts.
- flit_in  in  2*ADDR_W+DATA_W  incoming flit, same layout.
- flit_in_valid  in  1  router offers a flit.
- flit_in_ready  out  1  = !rx_full.
- misroute_cnt  out  8  saturating count of dropped misaddressed flits.

Behaviour:
- Reset (rst=0, async): FIFOs emptied, pointers/counts 0, FSM=IDLE, misroute_cnt=0. All outputs 0 except flit_in_ready=1. Any in-flight flit is discarded.

TX path:
- Push when proc_valid && !tx_full; entry = {proc_dest, NODE_ID, proc_data}.
- Full blocks push even if a pop occurs in the same cycle.
- flit_out_valid = !tx_empty; flit_out = head entry, registered FIFO storage; pop on flit_out_valid && flit_out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance, pointers wrap mod TX_DEPTH.
- A push into an empty FIFO appears on flit_out the next cycle.
- dest == NODE_ID is legal and is sent to the router unchanged.

RX path:
- Accept on flit_in_valid && flit_in_ready.
- If flit dest != NODE_ID: the flit is consumed but not stored; misroute_cnt increments, saturating at 255.
- Same-cycle accept and pop: count unchanged.

RX FSM, states IDLE, WAIT, DELIVER:
- IDLE: proc_ready_in && rx non-empty -> DELIVER; proc_ready_in && rx empty -> WAIT.
- WAIT: rx non-empty -> DELIVER; otherwise stay.
- DELIVER: data_valid=1, wd_NI=head payload, rx_src=head src; pop head; -> IDLE.
- data_valid and wd_NI are registered. Outside DELIVER, data_valid=0 and wd_NI holds its last value.
- A flit arriving during WAIT is delivered 1 cycle after it is written, i.e. 2 cycles after flit_in accept.
- A new receive needs proc_ready_in in IDLE; back-to-back receives take 2 cycles each.

Stall:
- proc_stall = (proc_ready_in && state != DELIVER) || (proc_valid && tx_full).
- Combinational, so the core freezes in the same cycle.

Test Plan:
- Send: TX empty, flit_out_ready=1; proc_valid=1, proc_dest=2, proc_data=0xDEADBEEF, NODE_ID=1 -> next cycle flit_out_valid=1, flit_out={2'b10, 2'b01, 32'hDEADBEEF}, proc_stall=0.
- TX full: flit_out_ready=0; 4 sends of 0x1..0x4, then a 5th send -> proc_stall=1 until flit_out_ready=1; flits emerge in order 1,2,3,4 then 5; no loss or duplication.
- Receive with data present: inject flit {dest=1, src=3, 0x12345678}, later proc_ready_in=1 for one cycle -> stall=1 that cycle; next cycle data_valid=1, wd_NI=0x12345678, rx_src=3, stall=0; mips_ni falls.
- Receive on empty: proc_ready_in=1 for 10 cycles, then inject 0xCAFE -> stall held high; data_valid pulses exactly once, 2 cycles after flit_in accept.
- Misroute and full: inject a flit with dest=2 -> misroute_cnt=1, RX unchanged. Fill RX with 4 valid flits -> flit_in_ready=0. One delivery plus a simultaneous inject -> count stays 4.
- Reset mid-operation: rst=0 while in WAIT with TX holding 3 entries -> immediately flit_out_valid=0, proc_stall=0, FSM=IDLE, counts 0.
